// File: rtl/gp01_ex1_seq_pkg.sv
// Shared gp01 definitions: sequencer state encodings and accumulator mode codes.
package gp01_ex1_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_LOG   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_MODE0 = 2'b00;
  localparam logic [1:0] SEL_MODE1 = 2'b01;
  localparam logic [1:0] SEL_MODE2 = 2'b10;
  localparam logic [1:0] SEL_STOP  = 2'b11;

endpackage

// File: rtl/gp01_rise_det.sv
// Rising-edge detector with a registered history bit and a synchronous clear.
// While clr is held the history reads 0, so a level that is already high on
// the first cycle after the clear is reported as an edge.
module gp01_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic rise
);

  logic hist_r;

  // Track the previously sampled input; reset and clear force it low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_r <= 1'b0;
    end else if (clr) begin
      hist_r <= 1'b0;
    end else begin
      hist_r <= d;
    end
  end

  assign rise = d & ~hist_r;

endmodule

// File: rtl/gp01_ex1_seq.sv
// Accumulator overflow-latency sequencer: steps the accumulator through modes
// 0..2, clears it before each run, and logs how many RUN cycles elapse until
// the first overflow edge (or a timeout) for each mode.
module gp01_ex1_seq
  import gp01_ex1_seq_pkg::*;
#(
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_data1_cfg,
  input  logic [2:0]       i_data2_cfg,
  input  logic             i_overflow,
  output logic [2:0]       o_data1,
  output logic [2:0]       o_data2,
  output logic [1:0]       o_sel,
  output logic             o_acc_rst_n,
  output logic             o_cnt_valid,
  output logic [CNT_W-1:0] o_cycles,
  output logic [1:0]       o_cnt_mode,
  output logic             o_timeout,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [3:0]       CLEAR_LAST  = 4'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_t           state_r;
  logic [3:0]       clr_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             timeout_hit_s;
  logic             rise_s;
  logic             hist_clr_s;
  logic [1:0]       sel_next_s;

  assign hist_clr_s = (state_r == ST_CLEAR);

  gp01_rise_det u_rise_det (
    .clk  (clk),
    .rst  (i_rst),
    .clr  (hist_clr_s),
    .d    (i_overflow),
    .rise (rise_s)
  );

  // Saturating RUN-cycle count as it will stand at the end of this cycle.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == CNT_MAX) begin
      cnt_next_s = cnt_r;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  assign timeout_hit_s = (cnt_next_s == TIMEOUT_VAL);
  assign sel_next_s    = o_sel + 2'b01;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      clr_cnt_r   <= 4'd0;
      cnt_r       <= {CNT_W{1'b0}};
      o_data1     <= 3'd0;
      o_data2     <= 3'd0;
      o_sel       <= SEL_MODE0;
      o_acc_rst_n <= 1'b0;
      o_cnt_valid <= 1'b0;
      o_cycles    <= {CNT_W{1'b0}};
      o_cnt_mode  <= SEL_MODE0;
      o_timeout   <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_cnt_valid <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_r     <= ST_CLEAR;
            clr_cnt_r   <= 4'd0;
            o_data1     <= i_data1_cfg;
            o_data2     <= i_data2_cfg;
            o_sel       <= SEL_MODE0;
            o_acc_rst_n <= 1'b0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_r == CLEAR_LAST) begin
            state_r     <= ST_RUN;
            cnt_r       <= {CNT_W{1'b0}};
            o_acc_rst_n <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + 4'd1;
          end
        end
        ST_RUN: begin
          cnt_r <= cnt_next_s;
          // An overflow edge wins over a coincident timeout.
          if (rise_s || timeout_hit_s) begin
            state_r     <= ST_LOG;
            o_acc_rst_n <= 1'b0;
            o_cnt_valid <= 1'b1;
            o_cycles    <= cnt_next_s;
            o_cnt_mode  <= o_sel;
            o_timeout   <= ~rise_s;
          end
        end
        ST_LOG: begin
          o_sel     <= sel_next_s;
          clr_cnt_r <= 4'd0;
          if (sel_next_s == SEL_STOP) begin
            state_r <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          o_acc_rst_n <= 1'b0;
          o_busy      <= 1'b0;
          o_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gp01_ex1_seq.sv
// Scoreboard bench for gp01_ex1_seq: stimulus pushes the expected log record
// for each mode, a negedge monitor pops and compares on every o_cnt_valid.
module tb_gp01_ex1_seq;

  localparam int CNT_W = 16;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [2:0]       i_data1_cfg;
  logic [2:0]       i_data2_cfg;
  logic             i_overflow;
  logic [2:0]       o_data1;
  logic [2:0]       o_data2;
  logic [1:0]       o_sel;
  logic             o_acc_rst_n;
  logic             o_cnt_valid;
  logic [CNT_W-1:0] o_cycles;
  logic [1:0]       o_cnt_mode;
  logic             o_timeout;
  logic             o_busy;
  logic             o_done;

  typedef struct packed {
    logic [CNT_W-1:0] cycles;
    logic [1:0]       mode;
    logic             timeout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  gp01_ex1_seq #(.CLEAR_CYCLES(2), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_data1_cfg (i_data1_cfg),
    .i_data2_cfg (i_data2_cfg),
    .i_overflow  (i_overflow),
    .o_data1     (o_data1),
    .o_data2     (o_data2),
    .o_sel       (o_sel),
    .o_acc_rst_n (o_acc_rst_n),
    .o_cnt_valid (o_cnt_valid),
    .o_cycles    (o_cycles),
    .o_cnt_mode  (o_cnt_mode),
    .o_timeout   (o_timeout),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every log strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (o_cnt_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got mode %0d cycles %0d, expected no strobe", o_cnt_mode, o_cycles);
      end else begin
        mon_e = exp_q.pop_front();
        check("log_cycles", 32'(o_cycles), 32'(mon_e.cycles));
        check("log_mode", 32'(o_cnt_mode), 32'(mon_e.mode));
        check("log_timeout", 32'(o_timeout), 32'(mon_e.timeout));
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_data1", 32'(o_data1), 32'd0);
    check("rst_data2", 32'(o_data2), 32'd0);
    check("rst_sel", 32'(o_sel), 32'd0);
    check("rst_acc_rst_n", 32'(o_acc_rst_n), 32'd0);
    check("rst_cnt_valid", 32'(o_cnt_valid), 32'd0);
    check("rst_cycles", 32'(o_cycles), 32'd0);
    check("rst_cnt_mode", 32'(o_cnt_mode), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
  endtask

  // Launch a sequence; returns with the DUT in its first CLEAR cycle.
  task automatic start_seq(input logic [2:0] d1, input logic [2:0] d2);
    i_data1_cfg = d1;
    i_data2_cfg = d2;
    i_start     = 1'b1;
    tick();
    i_start = 1'b0;
    check("start_data1", 32'(o_data1), 32'(d1));
    check("start_data2", 32'(o_data2), 32'(d2));
    check("start_sel", 32'(o_sel), 32'd0);
    check("start_busy", 32'(o_busy), 32'd1);
    check("start_done", 32'(o_done), 32'd0);
  endtask

  // One mode from first CLEAR cycle through LOG exit. edge_k=0 means no edge
  // (timeout); pre_high holds i_overflow high from CLEAR onward.
  task automatic run_mode(input int edge_k, input bit pre_high, input bit disturb, input logic [1:0] mode);
    exp_t e;
    int   run_len;
    run_len   = (edge_k == 0) ? TMO : edge_k;
    e.cycles  = pre_high ? CNT_W'(1) : CNT_W'(run_len);
    e.mode    = mode;
    e.timeout = (!pre_high && edge_k == 0);
    exp_q.push_back(e);
    if (pre_high) i_overflow = 1'b1;
    tick();
    check("clear_acc_rst_n", 32'(o_acc_rst_n), 32'd0);
    check("clear_busy", 32'(o_busy), 32'd1);
    tick();
    check("run_acc_rst_n", 32'(o_acc_rst_n), 32'd1);
    check("run_sel", 32'(o_sel), 32'(mode));
    if (pre_high) begin
      tick();
    end else begin
      for (int c = 1; c <= run_len; c++) begin
        if (disturb && c == 1) begin
          i_start     = 1'b1;
          i_data1_cfg = 3'b111;
          i_data2_cfg = 3'b111;
        end else begin
          i_start = 1'b0;
        end
        i_overflow = (edge_k != 0 && c == edge_k);
        tick();
      end
    end
    i_overflow = 1'b0;
    i_start    = 1'b0;
    check("log_acc_rst_n", 32'(o_acc_rst_n), 32'd0);
    tick();
  endtask

  task automatic check_done(input logic [2:0] d1, input logic [2:0] d2);
    check("done_flag", 32'(o_done), 32'd1);
    check("done_sel", 32'(o_sel), 32'd3);
    check("done_busy", 32'(o_busy), 32'd0);
    check("done_acc_rst_n", 32'(o_acc_rst_n), 32'd0);
    check("done_data1", 32'(o_data1), 32'(d1));
    check("done_data2", 32'(o_data2), 32'(d2));
  endtask

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_data1_cfg = 3'd0;
    i_data2_cfg = 3'd0;
    i_overflow  = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    check_reset_vals();

    // Edge at 5 in mode 0, start/cfg disturbance during mode 1 RUN.
    start_seq(3'b101, 3'b010);
    run_mode(5, 1'b0, 1'b0, 2'b00);
    run_mode(7, 1'b0, 1'b1, 2'b01);
    run_mode(2, 1'b0, 1'b0, 2'b10);
    check_done(3'b101, 3'b010);
    repeat (2) tick();
    check("done_held", 32'(o_done), 32'd1);

    // Restart from DONE: edges at 3, 7, 2.
    start_seq(3'b011, 3'b110);
    run_mode(3, 1'b0, 1'b0, 2'b00);
    run_mode(7, 1'b0, 1'b0, 2'b01);
    run_mode(2, 1'b0, 1'b0, 2'b10);
    check_done(3'b011, 3'b110);

    // Timeout, overflow already high at RUN entry, edge coincident with timeout.
    start_seq(3'b001, 3'b100);
    run_mode(0, 1'b0, 1'b0, 2'b00);
    run_mode(1, 1'b1, 1'b0, 2'b01);
    run_mode(TMO, 1'b0, 1'b0, 2'b10);
    check_done(3'b001, 3'b100);

    // Reset at RUN cycle 4 of mode 1, with an overflow edge in the same cycle.
    start_seq(3'b110, 3'b001);
    run_mode(4, 1'b0, 1'b0, 2'b00);
    repeat (2) tick();
    repeat (3) tick();
    i_overflow = 1'b1;
    i_rst      = 1'b1;
    tick();
    i_rst      = 1'b0;
    i_overflow = 1'b0;
    check_reset_vals();
    repeat (3) tick();
    check("idle_after_rst_busy", 32'(o_busy), 32'd0);
    check("pending_strobes", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gp01_ex1_seq.md
GP01_EX1_SEQ -- requirements
Module: gp01_ex1_seq

Interface
REQ-001 Param CLEAR_CYCLES, default 2: cycles the accumulator is held in reset before each mode run (range 1..15).
REQ-002 Param TIMEOUT_CYCLES, default 1023: maximum RUN cycles per mode before a forced log (range 1..65535).
REQ-003 Param CNT_W, default 16: cycle-counter width.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_start  in  1  level; sampled in IDLE/DONE to launch a sequence.
REQ-007 i_data1_cfg  in  3  operand 1 value for this sequence.
REQ-008 i_data2_cfg  in  3  operand 2 value for this sequence.
REQ-009 i_overflow  in  1  accumulator overflow flag (read side).
REQ-010 o_data1  out  3  operand 1 driven to accumulator.
REQ-011 o_data2  out  3  operand 2 driven to accumulator.
REQ-012 o_sel  out  2  accumulator mode select.
REQ-013 o_acc_rst_n  out  1  active-low reset driven to accumulator.
REQ-014 o_cnt_valid  out  1  one-cycle strobe: o_cycles/o_cnt_mode/o_timeout valid.
REQ-015 o_cycles  out  CNT_W  cycles from RUN entry to overflow (or timeout).
REQ-016 o_cnt_mode  out  2  mode the logged count belongs to.
REQ-017 o_timeout  out  1  logged count ended by timeout, not overflow.
REQ-018 o_busy  out  1  high in CLEAR, RUN, LOG.
REQ-019 o_done  out  1  high in DONE.

Function
REQ-020 FSM states SHALL be IDLE, CLEAR, RUN, LOG, DONE.
REQ-021 IDLE/DONE + i_start=1 -> CLEAR next cycle; o_data1/o_data2 latched from cfg inputs on that edge; o_sel SHALL be 00.
REQ-022 CLEAR: o_acc_rst_n=0 for exactly CLEAR_CYCLES cycles, then RUN; edge-detect history register cleared to 0.
REQ-023 RUN: o_acc_rst_n=1; counter starts at 0 on RUN entry and increments every RUN cycle, saturating at all-ones.
REQ-024 Overflow rising edge = i_overflow=1 with previous sampled value 0; i_overflow already high on first RUN cycle counts as an edge.
REQ-025 Edge in RUN cycle k (k=1 first RUN cycle) -> LOG next cycle with o_cycles=k, o_timeout=0.
REQ-026 No edge after TIMEOUT_CYCLES RUN cycles -> LOG with o_cycles=TIMEOUT_CYCLES, o_timeout=1; edge and timeout in same cycle -> o_timeout=0.
REQ-027 LOG lasts one cycle: o_cnt_valid=1, o_cnt_mode=current o_sel; o_cycles/o_cnt_mode/o_timeout hold until next LOG.
REQ-028 Exit LOG: o_sel incremented; new o_sel=11 -> DONE, else -> CLEAR.
REQ-029 DONE: o_done=1, o_sel=11, o_acc_rst_n=0; held until i_start or reset.
REQ-030 i_start ignored while o_busy=1; cfg inputs changing mid-sequence SHALL NOT affect o_data1/o_data2.
REQ-031 o_acc_rst_n=0 in IDLE, CLEAR, LOG, DONE.

Reset
REQ-032 i_rst=1 at a clk edge -> IDLE regardless of state, including mid-RUN; no LOG strobe issued for the aborted mode.
REQ-033 Reset values: o_data1=0, o_data2=0, o_sel=00, o_acc_rst_n=0, o_cnt_valid=0, o_cycles=0, o_cnt_mode=00, o_timeout=0, o_busy=0, o_done=0, counter=0, history=0.

Structure
REQ-034 Shared gp01 defines header SHALL hold state encodings and mode codes (SEL_MODE0..SEL_STOP=2'b11); no other constants there.
REQ-035 One sub-module gp01_rise_det (registered rising-edge detector with synchronous clear) SHALL provide REQ-024; remainder in gp01_ex1_seq.

Verification
REQ-036 Model asserts i_overflow on 5th RUN cycle of mode 0 -> o_cnt_valid pulse, o_cycles=5, o_cnt_mode=00, o_timeout=0, then CLEAR for 2 cycles.
REQ-037 Overflow edges at RUN cycles 3, 7, 2 for modes 0,1,2 -> three strobes (3/00, 7/01, 2/10), then o_done=1, o_sel=11.
REQ-038 TIMEOUT_CYCLES=8, i_overflow held 0 -> o_cycles=8, o_timeout=1, sequence advances to mode 01.
REQ-039 i_overflow high before RUN entry -> o_cycles=1, o_timeout=0.
REQ-040 i_rst pulsed at RUN cycle 4 of mode 01 -> next cycle IDLE, all outputs at REQ-033 values, no strobe.
REQ-041 i_start pulsed and cfg changed 3'b111 during RUN -> no restart, o_data1/o_data2 unchanged.
